// File: rtl/seq_mult_param.sv
// Radix-2 shift-add multiplier, one partial-product step per clock, with a
// per-operation signed/unsigned mode and valid/ready handshakes on both sides.
module seq_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 signed_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               mode_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     op_a, op_b, sum;
    logic               last_step;

    // Partial product lives in prod_q[2W-1:W]; the multiplier bits shift out of the bottom.
    always_comb begin
        addend    = prod_q[0] ? mcand_q : '0;
        op_a      = {mode_q & prod_q[2*WIDTH-1], prod_q[2*WIDTH-1:WIDTH]};
        op_b      = {mode_q & addend[WIDTH-1], addend};
        last_step = (cnt_q == CW'(WIDTH - 1));
        // The multiplier's sign bit carries weight -2^(W-1), so the last signed step subtracts.
        if (last_step && mode_q)
            sum = op_a + ~op_b + {{WIDTH{1'b0}}, 1'b1};
        else
            sum = op_a + op_b;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: datapath registers are reset too, so product_o reads 0 after any reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    mcand_q <= a_i;
                    prod_q  <= {{WIDTH{1'b0}}, b_i};
                    mode_q  <= signed_i;
                    cnt_q   <= '0;
                end
                CALC: begin
                    prod_q <= {sum, prod_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product_o = prod_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed checks of seq_mult_param at WIDTH=8 plus a randomised WIDTH=32
// back-to-back run with consumer stalls against a 64-bit arithmetic model.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid8 = 1'b0, signed8 = 1'b0, out_ready8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8;
    logic [15:0] product8;

    logic        in_valid32 = 1'b0, signed32 = 1'b0, out_ready32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        in_ready32, out_valid32;
    logic [63:0] product32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a_i(a8), .b_i(b8), .signed_i(signed8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .product_o(product8)
    );

    seq_mult_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .a_i(a32), .b_i(b32), .signed_i(signed32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .product_o(product32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 transaction with out_ready held high: checks latency, result, release.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready8), 64'd1);
        a8 = a; b8 = b; signed8 = s; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd8);
        chk({tag, "_product"}, 64'(product8), 64'(exp));
        @(negedge clk);
        chk({tag, "_idle"}, 64'({in_ready8, out_valid8}), 64'b10);
        out_ready8 = 1'b0;
    endtask

    initial begin
        int cyc;
        logic done;
        logic [63:0] exp32;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready8), 64'd1);
        chk("rst_out_valid", 64'(out_valid8), 64'd0);
        chk("rst_product", 64'(product8), 64'd0);
        rst_n = 1'b1;

        // Directed WIDTH=8 vectors
        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
        run8(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_min");
        run8(8'h03, 8'hFB, 1'b1, 16'hFFF1, "s_3_m5");
        run8(8'hFF, 8'h02, 1'b0, 16'h01FE, "u_ff_02");
        run8(8'hFF, 8'h02, 1'b1, 16'hFFFE, "s_ff_02");

        // Consumer stall with spurious in_valid pulses: 0x12*0x34 = 0x03A8
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; signed8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; signed8 = 1'b1;
        cyc = 0;
        while (!out_valid8 && cyc < 20) begin
            in_valid8 = ~in_valid8;
            @(negedge clk);
            cyc++;
        end
        chk("stall_latency", 64'(cyc), 64'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = ~in_valid8;
            chk("stall_hold", 64'({out_valid8, in_ready8, product8}), {46'd0, 2'b10, 16'h03A8});
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        chk("stall_release", 64'({out_valid8, in_ready8}), 64'b01);
        chk("idle_hold_product", 64'(product8), 64'h03A8);
        out_ready8 = 1'b0;

        // Reset after three CALC steps discards the operation
        a8 = 8'h55; b8 = 8'h66; signed8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_state", 64'({in_ready8, out_valid8}), 64'b10);
        chk("midrst_product", 64'(product8), 64'd0);
        run8(8'd7, 8'd6, 1'b0, 16'h002A, "u_7_6");

        // WIDTH=32 back-to-back random transactions with random stalls
        for (int t = 0; t < 1000; t++) begin
            a32 = $urandom;
            b32 = $urandom;
            signed32 = 1'($urandom_range(0, 1));
            if (signed32)
                exp32 = $signed({{32{a32[31]}}, a32}) * $signed({{32{b32[31]}}, b32});
            else
                exp32 = {32'd0, a32} * {32'd0, b32};
            in_valid32 = 1'b1;
            cyc = 0;
            while (!in_ready32 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 50) chk("w32_accept_timeout", 64'(in_ready32), 64'd1);
            @(negedge clk);
            in_valid32 = 1'b0;
            done = 1'b0;
            cyc = 0;
            while (!done && cyc < 400) begin
                out_ready32 = 1'($urandom_range(0, 1));
                if (out_valid32 && out_ready32) begin
                    chk("w32_product", product32, exp32);
                    done = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
            out_ready32 = 1'b0;
            if (!done) chk("w32_result_timeout", 64'(done), 64'd1);
            chk("w32_single_delivery", 64'(out_valid32), 64'd0);
        end

        // Directed WIDTH=32 extremes
        for (int k = 0; k < 2; k++) begin
            a32 = (k == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            b32 = a32;
            signed32 = (k == 0);
            exp32 = (k == 0) ? 64'h4000_0000_0000_0000 : 64'hFFFF_FFFE_0000_0001;
            in_valid32 = 1'b1;
            @(negedge clk);
            in_valid32 = 1'b0;
            cyc = 0;
            while (!out_valid32 && cyc < 60) begin
                @(negedge clk);
                cyc++;
            end
            chk("w32_extreme_latency", 64'(cyc), 64'd32);
            chk("w32_extreme_product", product32, exp32);
            out_ready32 = 1'b1;
            @(negedge clk);
            out_ready32 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential radix-2 shift-add multiplier with a per-transaction signed/unsigned mode and valid/ready handshakes on both sides. It computes one partial-product step per clock and is the general-width replacement for the fixed 8-bit shift-add multiplier in the multiplier family. It sits between an operand producer and a result consumer, and either side may stall.

## Interface
- WIDTH, default 32: operand width in bits. Legal range is WIDTH >= 2. The product is 2*WIDTH bits.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, synchronous and active-low, sampled on the rising edge of clk.
- in_valid  in  1  operand set is valid.
- in_ready  out  1  block can accept operands. High only in IDLE.
- a_i  in  WIDTH  multiplicand.
- b_i  in  WIDTH  multiplier.
- signed_i  in  1  1 = both operands are two's complement; 0 = both are unsigned.
- out_valid  out  1  product_o holds a finished result.
- out_ready  in  1  consumer accepts the result.
- product_o  out  2*WIDTH  result, registered.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - DONE: out_valid=1.
- IDLE -> CALC on in_valid&&in_ready. On that edge:
  - multiplicand register <= a_i.
  - product register <= {WIDTH'b0, b_i}.
  - mode register <= signed_i.
  - step counter <= 0.
  - Inputs are ignored in every other state.
- Each CALC cycle performs one iteration:
  - addend = product[0] ? multiplicand : 0.
  - Adder width is WIDTH+1. Its first operand is product[2W-1:W] extended by one bit; its second is the addend extended by one bit.
  - Extension bit is the sign bit when mode=1, zero when mode=0.
  - Last step (counter==WIDTH-1) with mode=1: subtract the addend (add its one's complement plus 1). Every other step adds.
  - product <= {sum[WIDTH:0], product[WIDTH-1:1]}.
  - counter increments.
- CALC -> DONE on the edge completing step WIDTH-1. product_o is then final, and out_valid is registered high on that same edge.
- DONE -> IDLE on out_valid&&out_ready. No new operand is accepted in the same cycle.
- In DONE, product_o and out_valid hold stable indefinitely while out_ready=0.
- product_o holds its value in IDLE and changes only when a new operation is loaded.
- Counter width is clog2(WIDTH)+1. The counter never wraps within an operation.
- Result is exact for all operand pairs, including the extremes:
  - signed -2^(W-1) * -2^(W-1) = 2^(2W-2).
  - unsigned (2^W-1)^2.

## Timing
- Reset (rst_n=0 at an edge), from any state including mid-CALC or DONE:
  - state=IDLE, in_ready=1, out_valid=0, product_o=0, counter=0, internal registers 0.
  - An in-flight operation is discarded with no output.
- Operand accepted at edge k: out_valid is first seen high after edge k+WIDTH, so latency is WIDTH cycles from acceptance.
- Minimum issue interval is WIDTH+2 cycles: accept, WIDTH steps, result handshake, return to IDLE.
- If out_ready is already high when out_valid rises, the result is consumed at edge k+WIDTH+1 and in_ready rises in the following cycle.
- in_ready and out_valid are never high together.
- in_ready is a pure decode of the state register. Neither ready output depends combinationally on any input.
- rst_n has priority over all handshakes in the same cycle.

## Test plan
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> product_o=0xFE01. out_valid rises exactly 8 cycles after the accept edge.
- WIDTH=8, signed, a=0x80, b=0x80 (-128*-128) -> 0x4000. Signed 0x03*0xFB (3*-5) -> 0xFFF1.
- WIDTH=8, a=0xFF, b=0x02: unsigned -> 0x01FE; signed -> 0xFFFE. Same operands, mode only differs.
- WIDTH=8, hold out_ready=0 for 5 cycles after out_valid:
  - out_valid, product_o and in_ready=0 stay stable.
  - in_valid pulses during CALC and DONE are ignored.
  - Releasing out_ready -> IDLE next cycle.
- WIDTH=8, assert rst_n=0 for one edge at CALC step 3:
  - Next cycle in_ready=1, out_valid=0, product_o=0.
  - A new 7*6 unsigned then yields 0x002A.
- WIDTH=32, 1000 random signed and unsigned back-to-back transactions with random out_ready stalls -> every product_o matches the reference model, and each result is delivered exactly once.
